// File: rtl/accel_dispatcher_pkg.sv
// Shared types and widths for the accelerator trace dispatcher.
// A trace entry holds the expected-response flag, the instruction word and two scalar operands.
package accel_dispatcher_pkg;

  localparam int unsigned NumEntries     = 64;
  localparam int unsigned XLEN           = 64;
  localparam int unsigned MaxOutstanding = 4;
  localparam int unsigned IterWidth      = 16;
  localparam int unsigned CycleWidth     = 64;

  localparam int unsigned PtrWidth     = $clog2(NumEntries);
  localparam int unsigned CntWidth     = $clog2(NumEntries + 1);
  localparam int unsigned OutWidth     = $clog2(MaxOutstanding + 1);
  localparam int unsigned InsnWidth    = 32;
  localparam int unsigned PayloadWidth = 1 + InsnWidth + 2 * XLEN;

  typedef logic [1:0] state_e;
  localparam state_e StIdle  = 2'd0;
  localparam state_e StRun   = 2'd1;
  localparam state_e StDrain = 2'd2;
  localparam state_e StDone  = 2'd3;

  typedef struct packed {
    logic                 resp_exp;
    logic [InsnWidth-1:0] insn;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
  } disp_payload_t;

endpackage

// File: rtl/accel_dispatcher_trace_mem.sv
// Trace storage: one write port, one asynchronous read port.
// The array carries no reset; validity is tracked by the entry count in the control logic.
module accel_dispatcher_trace_mem
  import accel_dispatcher_pkg::*;
(
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [PtrWidth-1:0] waddr_i,
  input  disp_payload_t       wdata_i,
  input  logic [PtrWidth-1:0] raddr_i,
  output disp_payload_t       rdata_o
);

  disp_payload_t mem_q [NumEntries];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/accel_dispatcher_replay.sv
// Replays a run-time loaded vector-instruction trace N times onto the accelerator request
// channel, limiting responses in flight and counting cycles spent in RUN and DRAIN.
module accel_dispatcher_replay
  import accel_dispatcher_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [PayloadWidth-1:0] load_data_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [IterWidth-1:0]    num_iter_i,
  output logic                    acc_req_valid_o,
  input  logic                    acc_req_ready_i,
  output logic [InsnWidth-1:0]    acc_req_insn_o,
  output logic [XLEN-1:0]         acc_req_rs1_o,
  output logic [XLEN-1:0]         acc_req_rs2_o,
  input  logic                    acc_resp_valid_i,
  output logic                    acc_resp_ready_o,
  input  logic                    acc_idle_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [CycleWidth-1:0]   cycles_o
);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   count_q;
  logic [PtrWidth-1:0]   rd_ptr_q;
  logic [IterWidth-1:0]  iter_q, iter_max_q;
  logic [OutWidth-1:0]   out_q;
  logic [CycleWidth-1:0] cycles_q;
  logic                  err_q;

  disp_payload_t entry;
  logic has_trace, load_fire, req_fire, last_entry, last_iter;
  logic start_run, clear_fire, busy, out_full, resp_inc;

  accel_dispatcher_trace_mem u_trace_mem (
    .clk_i   (clk_i),
    .we_i    (load_fire),
    .waddr_i (PtrWidth'(count_q)),
    .wdata_i (disp_payload_t'(load_data_i)),
    .raddr_i (rd_ptr_q),
    .rdata_o (entry)
  );

  assign has_trace    = (count_q != '0);
  assign load_ready_o = (state_q == StIdle) && (count_q != CntWidth'(NumEntries));
  assign load_fire    = load_valid_i && load_ready_o;

  // Entries that expect a response are held back while the credit limit is reached
  assign out_full        = (out_q == OutWidth'(MaxOutstanding));
  assign acc_req_valid_o = (state_q == StRun) && !(entry.resp_exp && out_full);
  assign req_fire        = acc_req_valid_o && acc_req_ready_i;
  assign resp_inc        = req_fire && entry.resp_exp;

  assign last_entry = (rd_ptr_q == PtrWidth'(count_q - CntWidth'(1)));
  assign last_iter  = (iter_q == iter_max_q - IterWidth'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_i && has_trace) state_d = StRun;
      StRun:   if (req_fire && last_entry && last_iter) state_d = StDrain;
      StDrain: if ((out_q == '0) && acc_idle_i) state_d = StDone;
      StDone: begin
        if (start_i)      state_d = StRun;
        else if (clear_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // start_i takes priority over clear_i wherever both are honoured
  assign start_run  = (state_d == StRun) && (state_q != StRun);
  assign clear_fire = clear_i && (((state_q == StIdle) && !(start_i && has_trace)) ||
                                  ((state_q == StDone) && !start_i));
  assign busy       = (state_q == StRun) || (state_q == StDrain);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      iter_q     <= '0;
      iter_max_q <= IterWidth'(1);
      out_q      <= '0;
      cycles_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;

      if (clear_fire)     count_q <= '0;
      else if (load_fire) count_q <= count_q + CntWidth'(1);

      if (start_run) begin
        rd_ptr_q   <= '0;
        iter_q     <= '0;
        iter_max_q <= (num_iter_i == '0) ? IterWidth'(1) : num_iter_i;
      end else if (req_fire) begin
        rd_ptr_q <= last_entry ? '0 : rd_ptr_q + PtrWidth'(1);
        if (last_entry) iter_q <= iter_q + IterWidth'(1);
      end

      // A simultaneous issue and response cancel; a response with nothing in flight is an error
      if (resp_inc && !acc_resp_valid_i) begin
        out_q <= out_q + OutWidth'(1);
      end else if (!resp_inc && acc_resp_valid_i) begin
        if (out_q == '0) err_q <= 1'b1;
        else             out_q <= out_q - OutWidth'(1);
      end

      if (start_run)                    cycles_q <= '0;
      else if (busy && cycles_q != '1)  cycles_q <= cycles_q + CycleWidth'(1);
    end
  end

  assign acc_req_insn_o   = entry.insn;
  assign acc_req_rs1_o    = entry.rs1;
  assign acc_req_rs2_o    = entry.rs2;
  assign acc_resp_ready_o = 1'b1;
  assign busy_o           = busy;
  assign done_o           = (state_q == StDone);
  assign err_o            = err_q;
  assign cycles_o         = cycles_q;

endmodule

// File: tb/tb_accel_dispatcher_replay.sv
// Directed bench for the trace dispatcher: expected requests are queued when replay starts
// and compared against every request handshake the dispatcher produces.
module tb_accel_dispatcher_replay;
  import accel_dispatcher_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  load_valid_i;
  logic                  load_ready_o;
  disp_payload_t         load_data;
  logic                  clear_i;
  logic                  start_i;
  logic [IterWidth-1:0]  num_iter_i;
  logic                  acc_req_valid_o;
  logic                  acc_req_ready_i;
  logic [InsnWidth-1:0]  acc_req_insn_o;
  logic [XLEN-1:0]       acc_req_rs1_o;
  logic [XLEN-1:0]       acc_req_rs2_o;
  logic                  acc_resp_valid_i;
  logic                  acc_resp_ready_o;
  logic                  acc_idle_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [CycleWidth-1:0] cycles_o;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned hs     = 0;
  int unsigned base   = 0;

  disp_payload_t tr[$];
  disp_payload_t exp_q[$];

  always #5 clk = ~clk;

  accel_dispatcher_replay dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .load_valid_i     (load_valid_i),
    .load_ready_o     (load_ready_o),
    .load_data_i      (load_data),
    .clear_i          (clear_i),
    .start_i          (start_i),
    .num_iter_i       (num_iter_i),
    .acc_req_valid_o  (acc_req_valid_o),
    .acc_req_ready_i  (acc_req_ready_i),
    .acc_req_insn_o   (acc_req_insn_o),
    .acc_req_rs1_o    (acc_req_rs1_o),
    .acc_req_rs2_o    (acc_req_rs2_o),
    .acc_resp_valid_i (acc_resp_valid_i),
    .acc_resp_ready_o (acc_resp_ready_o),
    .acc_idle_i       (acc_idle_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .cycles_o         (cycles_o)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic disp_payload_t mk(input int unsigned i, input logic re);
    disp_payload_t p;
    p.resp_exp = re;
    p.insn     = 32'h0000_0057 | (32'(i) << 12);
    p.rs1      = {32'hA5A5_0000 | 32'(i), 32'h0000_1000 + 32'(i)};
    p.rs2      = ~p.rs1 ^ (64'(i) * 64'd3);
    return p;
  endfunction

  // Score any handshake present in this cycle, then advance one clock
  task automatic tick();
    disp_payload_t e;
    #1;
    if (acc_req_valid_o && acc_req_ready_i) begin
      hs++;
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", {32'd0, acc_req_insn_o, acc_req_rs1_o, acc_req_rs2_o}, '0);
      end else begin
        e = exp_q.pop_front();
        chk("issue_payload", {32'd0, acc_req_insn_o, acc_req_rs1_o, acc_req_rs2_o},
            {32'd0, e.insn, e.rs1, e.rs2});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input disp_payload_t p);
    load_valid_i = 1'b1;
    load_data    = p;
    tr.push_back(p);
    tick();
    load_valid_i = 1'b0;
  endtask

  task automatic start(input int unsigned n);
    int unsigned reps = (n == 0) ? 1 : n;
    for (int r = 0; r < int'(reps); r++)
      foreach (tr[k]) exp_q.push_back(tr[k]);
    start_i    = 1'b1;
    num_iter_i = IterWidth'(n);
    tick();
    start_i = 1'b0;
  endtask

  task automatic clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    tr.delete();
  endtask

  initial begin
    rst_i = 1'b1; load_valid_i = 1'b0; load_data = '0; clear_i = 1'b0; start_i = 1'b0;
    num_iter_i = '0; acc_req_ready_i = 1'b1; acc_resp_valid_i = 1'b0; acc_idle_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("rst_load_ready", 192'(load_ready_o), 192'(1));
    chk("rst_resp_ready", 192'(acc_resp_ready_o), 192'(1));
    chk("rst_req_valid", 192'(acc_req_valid_o), 192'(0));
    chk("rst_busy", 192'(busy_o), 192'(0));
    chk("rst_done", 192'(done_o), 192'(0));
    chk("rst_err", 192'(err_o), 192'(0));
    chk("rst_cycles", 192'(cycles_o), 192'(0));

    // Three entries replayed twice back to back
    for (int k = 0; k < 3; k++) load(mk(k, 1'b0));
    start(2);
    chk("t1_first_valid", 192'(acc_req_valid_o), 192'(1));
    chk("t1_busy", 192'(busy_o), 192'(1));
    base = hs;
    repeat (6) tick();
    chk("t1_handshakes", 192'(hs - base), 192'(6));
    chk("t1_drain_valid", 192'(acc_req_valid_o), 192'(0));
    chk("t1_drain_busy", 192'(busy_o), 192'(1));
    chk("t1_drain_done", 192'(done_o), 192'(0));
    acc_idle_i = 1'b1;
    tick();
    chk("t1_done", 192'(done_o), 192'(1));
    chk("t1_busy_off", 192'(busy_o), 192'(0));
    chk("t1_cycles", 192'(cycles_o), 192'(7));
    chk("t1_queue_empty", 192'(exp_q.size()), 192'(0));

    // Clear from DONE, then start with an empty trace is ignored
    clear();
    chk("t4_clear_done", 192'(done_o), 192'(0));
    chk("t4_clear_ready", 192'(load_ready_o), 192'(1));
    start(1);
    chk("t4_empty_busy", 192'(busy_o), 192'(0));
    chk("t4_empty_valid", 192'(acc_req_valid_o), 192'(0));

    // Credit limit: eight entries expecting responses, none returned at first
    acc_idle_i = 1'b0;
    for (int k = 0; k < 8; k++) load(mk(10 + k, 1'b1));
    start(1);
    base = hs;
    repeat (6) tick();
    chk("t2_credit_issue", 192'(hs - base), 192'(4));
    chk("t2_credit_stall", 192'(acc_req_valid_o), 192'(0));
    acc_resp_valid_i = 1'b1;
    tick();
    acc_resp_valid_i = 1'b0;
    repeat (4) tick();
    chk("t2_one_more", 192'(hs - base), 192'(5));
    chk("t2_stall_again", 192'(acc_req_valid_o), 192'(0));

    // Issue and response in the same cycle at two in flight, then underflow
    acc_req_ready_i  = 1'b0;
    acc_resp_valid_i = 1'b1;
    tick();
    tick();
    acc_req_ready_i = 1'b1;
    tick();
    chk("t3_paired_issue", 192'(hs - base), 192'(6));
    acc_req_ready_i = 1'b0;
    tick();
    tick();
    acc_resp_valid_i = 1'b0;
    chk("t3_no_err_yet", 192'(err_o), 192'(0));
    acc_resp_valid_i = 1'b1;
    tick();
    acc_resp_valid_i = 1'b0;
    chk("t3_err_set", 192'(err_o), 192'(1));
    acc_req_ready_i = 1'b1;
    tick();
    tick();
    chk("t3_all_issued", 192'(hs - base), 192'(8));
    chk("t3_drain_valid", 192'(acc_req_valid_o), 192'(0));
    acc_resp_valid_i = 1'b1;
    tick();
    tick();
    acc_resp_valid_i = 1'b0;
    chk("t3_drain_wait_idle", 192'(busy_o), 192'(1));
    acc_idle_i = 1'b1;
    tick();
    chk("t3_done", 192'(done_o), 192'(1));
    chk("t3_err_sticky", 192'(err_o), 192'(1));
    chk("t3_queue_empty", 192'(exp_q.size()), 192'(0));

    // DRAIN held by a busy accelerator for ten cycles
    clear();
    acc_idle_i = 1'b0;
    for (int k = 0; k < 3; k++) load(mk(30 + k, 1'b0));
    start(1);
    repeat (3) tick();
    repeat (10) tick();
    chk("t5_drain_busy", 192'(busy_o), 192'(1));
    chk("t5_drain_not_done", 192'(done_o), 192'(0));
    acc_idle_i = 1'b1;
    tick();
    chk("t5_done", 192'(done_o), 192'(1));
    chk("t5_cycles", 192'(cycles_o), 192'(14));
    tick();
    chk("t5_cycles_held", 192'(cycles_o), 192'(14));

    // Fill every entry; an extra write is dropped
    clear();
    for (int k = 0; k < int'(NumEntries); k++) load(mk(100 + k, 1'b0));
    chk("t4_full_ready", 192'(load_ready_o), 192'(0));
    load_valid_i = 1'b1;
    load_data    = mk(999, 1'b0);
    tick();
    load_valid_i = 1'b0;
    chk("t4_full_still", 192'(load_ready_o), 192'(0));
    start(1);
    base = hs;
    repeat (NumEntries) tick();
    chk("t4_full_replay", 192'(hs - base), 192'(NumEntries));
    chk("t4_full_drain_valid", 192'(acc_req_valid_o), 192'(0));
    tick();
    chk("t4_full_done", 192'(done_o), 192'(1));
    chk("t4_queue_empty", 192'(exp_q.size()), 192'(0));

    // Restart from DONE with the same trace, then reset mid-run
    start(1);
    repeat (5) tick();
    chk("t6_running", 192'(busy_o), 192'(1));
    rst_i = 1'b1;
    #1;
    tick();
    rst_i = 1'b0;
    chk("t6_rst_valid", 192'(acc_req_valid_o), 192'(0));
    chk("t6_rst_busy", 192'(busy_o), 192'(0));
    chk("t6_rst_count", 192'(load_ready_o), 192'(1));
    chk("t6_rst_err", 192'(err_o), 192'(0));
    chk("t6_rst_cycles", 192'(cycles_o), 192'(0));
    exp_q.delete();
    tr.delete();
    for (int k = 0; k < 2; k++) load(mk(200 + k, 1'b0));
    start(0);
    chk("t6_restart_valid", 192'(acc_req_valid_o), 192'(1));
    base = hs;
    repeat (2) tick();
    chk("t6_single_iter", 192'(hs - base), 192'(2));
    chk("t6_drain_valid", 192'(acc_req_valid_o), 192'(0));
    tick();
    chk("t6_done", 192'(done_o), 192'(1));
    chk("t6_queue_empty", 192'(exp_q.size()), 192'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
